e203_exu_stim_seq: RTL and testbench



---
 rtl/e203_exu_stim_pkg.sv | 41 ++++
 rtl/e203_exu_stim_lfsr.sv | 39 +++
 rtl/e203_exu_stim_seq.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_e203_exu_stim_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_stim_pkg
// Description : Shared types and helpers for the EXU stimulus sequencer.
//               Phase encoding, LFSR polynomial, per-channel seed spreading
//               and the single-step Galois LFSR function.
// Revision    : 1.0 - initial release
// ============================================================================
package e203_exu_stim_pkg;

  // Sequencer phase encoding, visible on the phase output.
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_RST  = 3'd1,
    PH_ZERO = 3'd2,
    PH_ONES = 3'd3,
    PH_WALK = 3'd4,
    PH_RAND = 3'd5,
    PH_DONE = 3'd6
  } phase_e;

  localparam logic [31:0] c_lfsr_poly   = 32'h8020_0003;
  localparam logic [31:0] c_seed_spread = 32'h9E37_79B9;

  // One step of a right-shifting Galois LFSR: shift toward bit 0 and fold
  // the polynomial mask back in whenever a one falls out of bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_poly : 32'h0);
  endfunction

  // Seed for channel c. An all-zero state would lock the LFSR, so it is
  // replaced by 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] base,
                                            input int unsigned c);
    logic [31:0] v;
    v = base ^ (32'(c) * c_seed_spread);
    chan_seed = (v == 32'h0) ? 32'h1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e203_exu_stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_stim_lfsr
// Description : One 32-bit Galois LFSR per stimulus channel.
//               Ports: clk, rst_n (async active-low), load (reload SEED),
//               step (advance one state), state (current value),
//               state_nxt (value after the next step).
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_stim_lfsr
  import e203_exu_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state,
  output logic [31:0] state_nxt
);

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= SEED;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state     = r_state;
  assign state_nxt = lfsr_next(r_state);

endmodule
`default_nettype wire

// File: rtl/e203_exu_stim_seq.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_stim_seq
// Description : Self-test stimulus sequencer for the E203 EXU input bundle.
//               Program: DUT reset pulse, all-zeros, all-ones, optional
//               walking-one, NRAND pseudo-random patterns, done.
//               Each pattern is held HOLD cycles; cmp_match is scored on the
//               last hold cycle of every pattern.
//               Optional feature macro: E203_EXU_STIM_WALK_EN (adds WALK).
// Ports       : clk, rst_n          clock, async active-low reset
//               start, abort        controller pulses (abort wins)
//               cmp_match           DUT-vs-reference match, every cycle
//               stim_data           NCH*CW flattened stimulus
//               stim_rst_n          reset to the DUT under test
//               stim_vld, phase     pattern-valid flag, current phase
//               pat_idx             WALK/RAND pattern index
//               busy, done          program status
//               err_cnt, first_err  saturating fail count, first RAND fail
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_stim_seq
  import e203_exu_stim_pkg::*;
#(
  parameter int          NCH     = 48,
  parameter int          CW      = 32,
  parameter int          HOLD    = 2,
  parameter int          RST_CYC = 3,
  parameter int          NRAND   = 100,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cmp_match,
  output logic [NCH*CW-1:0]   stim_data,
  output logic                stim_rst_n,
  output logic                stim_vld,
  output logic [2:0]          phase,
  output logic [7:0]          pat_idx,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_cnt,
  output logic [7:0]          first_err
);

  localparam int c_dw = NCH * CW;

  phase_e            r_phase, w_phase_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [7:0]        r_idx, w_idx_nxt;
  logic [c_dw-1:0]   r_data, w_data_nxt;
  logic              r_stim_rst_n, w_stim_rst_n_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [15:0]       r_err_cnt;
  logic [7:0]        r_first_err;
  logic              r_err_seen;

  logic              w_last;
  logic              w_pat_phase;
  logic              w_accept;
  logic              w_fail;
  logic              w_lfsr_step;
  logic [31:0]       w_lfsr_q   [NCH];
  logic [31:0]       w_lfsr_nxt [NCH];

  // Last cycle of the current RST interval or pattern hold.
  assign w_last = (r_phase == PH_RST) ? (r_cnt == 16'(RST_CYC - 1))
                                      : (r_cnt == 16'(HOLD - 1));

  assign w_pat_phase = (r_phase == PH_ZERO) || (r_phase == PH_ONES) ||
                       (r_phase == PH_WALK) || (r_phase == PH_RAND);

  assign w_accept    = (r_phase == PH_IDLE) && !r_busy && start && !abort;
  // An abort cancels the pattern in flight, so that cycle is not scored.
  assign w_fail      = w_last && w_pat_phase && !abort && !cmp_match;
  assign w_lfsr_step = (r_phase == PH_RAND) && w_last;

  for (genvar c = 0; c < NCH; c++) begin : g_lfsr
    e203_exu_stim_lfsr #(
      .SEED (chan_seed(SEED, c))
    ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_accept),
      .step      (w_lfsr_step),
      .state     (w_lfsr_q[c]),
      .state_nxt (w_lfsr_nxt[c])
    );
  end

  // --------------------------------------------------------------------------
  // Next-state: phase, hold counter, pattern index
  // --------------------------------------------------------------------------
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_phase)
      PH_IDLE: begin
        if (w_accept) begin
          w_phase_nxt = PH_RST;
          w_cnt_nxt   = 16'd0;
        end
      end
      PH_RST: begin
        if (w_last) begin
          w_phase_nxt = PH_ZERO;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      PH_ZERO: begin
        if (w_last) begin
          w_phase_nxt = PH_ONES;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      PH_ONES: begin
        if (w_last) begin
`ifdef E203_EXU_STIM_WALK_EN
          w_phase_nxt = PH_WALK;
`else
          w_phase_nxt = PH_RAND;
`endif
          w_cnt_nxt = 16'd0;
          w_idx_nxt = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
`ifdef E203_EXU_STIM_WALK_EN
      PH_WALK: begin
        if (w_last) begin
          w_cnt_nxt = 16'd0;
          if (r_idx == 8'(CW - 1)) begin
            w_phase_nxt = PH_RAND;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
`endif
      PH_RAND: begin
        if (w_last) begin
          w_cnt_nxt = 16'd0;
          if (r_idx == 8'(NRAND - 1)) begin
            w_phase_nxt = PH_DONE;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      PH_DONE: begin
        w_phase_nxt = PH_IDLE;
        w_cnt_nxt   = 16'd0;
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_cnt_nxt   = 16'd0;
        w_idx_nxt   = 8'd0;
      end
    endcase

    if (abort) begin
      w_phase_nxt = PH_IDLE;
      w_cnt_nxt   = 16'd0;
      w_idx_nxt   = 8'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: values the output registers take with the next phase.
  // Keying off the next phase keeps every output aligned with phase.
  // --------------------------------------------------------------------------
`ifdef E203_EXU_STIM_WALK_EN
  logic [CW-1:0] w_walk_bit;
  assign w_walk_bit = CW'(32'd1 << w_idx_nxt);
`endif

  always_comb begin
    w_data_nxt       = r_data;
    w_vld_nxt        = 1'b0;
    w_stim_rst_n_nxt = 1'b1;
    w_done_nxt       = 1'b0;
    w_busy_nxt       = r_busy;
    case (w_phase_nxt)
      PH_IDLE: begin
        w_data_nxt = '0;
        w_busy_nxt = 1'b0;
      end
      PH_RST: begin
        w_data_nxt       = '0;
        w_stim_rst_n_nxt = 1'b0;
        w_busy_nxt       = 1'b1;
      end
      PH_ZERO: begin
        w_data_nxt = '0;
        w_vld_nxt  = 1'b1;
      end
      PH_ONES: begin
        w_data_nxt = '1;
        w_vld_nxt  = 1'b1;
      end
`ifdef E203_EXU_STIM_WALK_EN
      PH_WALK: begin
        for (int c = 0; c < NCH; c++) begin
          w_data_nxt[c*CW +: CW] = w_walk_bit;
        end
        w_vld_nxt = 1'b1;
      end
`endif
      PH_RAND: begin
        w_vld_nxt = 1'b1;
        // First pattern shows the freshly loaded seed; later patterns show
        // the state the LFSR steps to at the same edge.
        if (r_phase != PH_RAND) begin
          for (int c = 0; c < NCH; c++) begin
            w_data_nxt[c*CW +: CW] = w_lfsr_q[c][CW-1:0];
          end
        end else if (w_last) begin
          for (int c = 0; c < NCH; c++) begin
            w_data_nxt[c*CW +: CW] = w_lfsr_nxt[c][CW-1:0];
          end
        end
      end
      PH_DONE: begin
        w_data_nxt = '0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_data_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, output and scoreboard registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= PH_IDLE;
      r_cnt        <= 16'd0;
      r_idx        <= 8'd0;
      r_data       <= '0;
      r_stim_rst_n <= 1'b0;
      r_vld        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_cnt    <= 16'd0;
      r_first_err  <= 8'hFF;
      r_err_seen   <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_data       <= w_data_nxt;
      r_stim_rst_n <= w_stim_rst_n_nxt;
      r_vld        <= w_vld_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      if (w_accept) begin
        r_err_cnt   <= 16'd0;
        r_first_err <= 8'hFF;
        r_err_seen  <= 1'b0;
      end else if (w_fail) begin
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        // A separate flag is used because pattern 255 would alias 8'hFF.
        if ((r_phase == PH_RAND) && !r_err_seen) begin
          r_first_err <= r_idx;
          r_err_seen  <= 1'b1;
        end
      end
    end
  end

  assign stim_data  = r_data;
  assign stim_rst_n = r_stim_rst_n;
  assign stim_vld   = r_vld;
  assign phase      = r_phase;
  assign pat_idx    = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_cnt    = r_err_cnt;
  assign first_err  = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_stim_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_exu_stim_seq
// Description : Self-checking bench for e203_exu_stim_seq (NCH=2, CW=8,
//               HOLD=2, RST_CYC=3, NRAND=4). The expected per-cycle trace of
//               a whole program is built from the phase rules, then compared
//               cycle by cycle while cmp_match is driven directed or random.
//               Honours E203_EXU_STIM_WALK_EN if defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_exu_stim_seq;

  localparam int          P_NCH   = 2;
  localparam int          P_CW    = 8;
  localparam int          P_HOLD  = 2;
  localparam int          P_RST   = 3;
  localparam int          P_NRAND = 4;
  localparam logic [31:0] P_SEED  = 32'h1;
`ifdef E203_EXU_STIM_WALK_EN
  localparam int          P_WALK  = 1;
`else
  localparam int          P_WALK  = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    abort;
  logic                    cmp_match;
  logic [P_NCH*P_CW-1:0]   stim_data;
  logic                    stim_rst_n;
  logic                    stim_vld;
  logic [2:0]              phase;
  logic [7:0]              pat_idx;
  logic                    busy;
  logic                    done;
  logic [15:0]             err_cnt;
  logic [7:0]              first_err;

  e203_exu_stim_seq #(
    .NCH     (P_NCH),
    .CW      (P_CW),
    .HOLD    (P_HOLD),
    .RST_CYC (P_RST),
    .NRAND   (P_NRAND),
    .SEED    (P_SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cmp_match  (cmp_match),
    .stim_data  (stim_data),
    .stim_rst_n (stim_rst_n),
    .stim_vld   (stim_vld),
    .phase      (phase),
    .pat_idx    (pat_idx),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .first_err  (first_err)
  );

  always #5 clk = ~clk;

  // Expected view of one cycle of the program.
  typedef struct {
    logic [2:0]  ph;
    logic [15:0] data;
    logic        vld;
    logic        rstn;
    logic        dn;
    logic [7:0]  idx;
    bit          scored;
    bit          is_rand;
  } exp_t;

  exp_t        trace[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_err   = 16'd0;
  logic [7:0]  exp_first = 8'hFF;
  bit          seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic push(input logic [2:0] ph, input logic [15:0] d, input logic v,
                      input logic rn, input logic dn, input logic [7:0] ix,
                      input bit sc, input bit rnd);
    exp_t e;
    e.ph = ph; e.data = d; e.vld = v; e.rstn = rn; e.dn = dn;
    e.idx = ix; e.scored = sc; e.is_rand = rnd;
    trace.push_back(e);
  endtask

  // Whole-program trace, one entry per cycle after the start edge,
  // ending with the cycle back in IDLE.
  task automatic build_trace();
    logic [31:0] s [P_NCH];
    logic [15:0] d;
    logic [7:0]  wb;
    trace.delete();
    for (int i = 0; i < P_RST; i++) push(3'd1, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int h = 0; h < P_HOLD; h++) push(3'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, h == P_HOLD-1, 1'b0);
    for (int h = 0; h < P_HOLD; h++) push(3'd3, 16'hFFFF, 1'b1, 1'b1, 1'b0, 8'd0, h == P_HOLD-1, 1'b0);
    if (P_WALK != 0) begin
      for (int k = 0; k < P_CW; k++) begin
        wb = 8'(1 << k);
        d  = {wb, wb};
        for (int h = 0; h < P_HOLD; h++) push(3'd4, d, 1'b1, 1'b1, 1'b0, 8'(k), h == P_HOLD-1, 1'b0);
      end
    end
    for (int c = 0; c < P_NCH; c++) begin
      s[c] = P_SEED ^ (32'(c) * 32'h9E37_79B9);
      if (s[c] == 32'h0) s[c] = 32'h1;
    end
    for (int p = 0; p < P_NRAND; p++) begin
      for (int c = 0; c < P_NCH; c++) d[c*P_CW +: P_CW] = s[c][P_CW-1:0];
      for (int h = 0; h < P_HOLD; h++) push(3'd5, d, 1'b1, 1'b1, 1'b0, 8'(p), h == P_HOLD-1, 1'b1);
      for (int c = 0; c < P_NCH; c++) s[c] = m_step(s[c]);
    end
    push(3'd6, 16'h0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    push(3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_cycle(input int i);
    exp_t e;
    e = trace[i];
    chk($sformatf("phase@%0d", i),     32'(phase),      32'(e.ph));
    chk($sformatf("stim_data@%0d", i), 32'(stim_data),  32'(e.data));
    chk($sformatf("stim_vld@%0d", i),  32'(stim_vld),   32'(e.vld));
    chk($sformatf("stim_rst_n@%0d", i),32'(stim_rst_n), 32'(e.rstn));
    chk($sformatf("done@%0d", i),      32'(done),       32'(e.dn));
    chk($sformatf("pat_idx@%0d", i),   32'(pat_idx),    32'(e.idx));
    chk($sformatf("err_cnt@%0d", i),   32'(err_cnt),    32'(exp_err));
    chk($sformatf("first_err@%0d", i), 32'(first_err),  32'(exp_first));
    if (e.ph != 3'd6) chk($sformatf("busy@%0d", i), 32'(busy), (e.ph == 3'd0) ? 32'd0 : 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".phase"},      32'(phase),      32'd0);
    chk({tag, ".stim_data"},  32'(stim_data),  32'd0);
    chk({tag, ".stim_rst_n"}, 32'(stim_rst_n), 32'd0);
    chk({tag, ".stim_vld"},   32'(stim_vld),   32'd0);
    chk({tag, ".pat_idx"},    32'(pat_idx),    32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".done"},       32'(done),       32'd0);
    chk({tag, ".err_cnt"},    32'(err_cnt),    32'd0);
    chk({tag, ".first_err"},  32'(first_err),  32'hFF);
  endtask

  // mode: 0 always match, 1 miss on RAND pattern 2 only, 2 never match,
  //       3 random (with ignored start pulses mid-run).
  // stop_kind: 1 abort at entry stop_at, 2 async reset at entry stop_at.
  task automatic run_program(input int mode, input int stop_at, input int stop_kind);
    logic m;
    build_trace();
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_err   = 16'd0;
    exp_first = 8'hFF;
    seen      = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      check_cycle(i);
      if (i == stop_at) begin
        if (stop_kind == 1) begin
          cmp_match = 1'b1;
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort.phase",      32'(phase),      32'd0);
          chk("abort.busy",       32'(busy),       32'd0);
          chk("abort.stim_data",  32'(stim_data),  32'd0);
          chk("abort.stim_rst_n", 32'(stim_rst_n), 32'd1);
          chk("abort.stim_vld",   32'(stim_vld),   32'd0);
          chk("abort.done",       32'(done),       32'd0);
          chk("abort.err_cnt",    32'(err_cnt),    32'(exp_err));
          chk("abort.first_err",  32'(first_err),  32'(exp_first));
          @(posedge clk); #1;
          chk("abort.done_after", 32'(done),       32'd0);
          chk("abort.phase_after",32'(phase),      32'd0);
        end else begin
          #2 rst_n = 1'b0;
          #1;
          check_reset_values("async_rst");
          exp_err   = 16'd0;
          exp_first = 8'hFF;
          @(negedge clk);
          rst_n = 1'b1;
          @(posedge clk); #1;
          chk("post_rst.stim_rst_n", 32'(stim_rst_n), 32'd1);
          chk("post_rst.phase",      32'(phase),      32'd0);
        end
        return;
      end
      case (mode)
        0:       m = 1'b1;
        1:       m = !(trace[i].is_rand && trace[i].scored && trace[i].idx == 8'd2);
        2:       m = 1'b0;
        default: m = ($urandom_range(0, 3) != 0);
      endcase
      cmp_match = m;
      if (mode == 3 && trace[i].vld && $urandom_range(0, 7) == 0) start = 1'b1;
      if (trace[i].scored && !m) begin
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        if (trace[i].is_rand && !seen) begin
          exp_first = trace[i].idx;
          seen      = 1'b1;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    cmp_match = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cmp_match = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.stim_rst_n", 32'(stim_rst_n), 32'd1);
    chk("idle.stim_data",  32'(stim_data),  32'd0);
    chk("idle.phase",      32'(phase),      32'd0);

    // Clean run, single RAND miss, all misses
    run_program(0, -1, 0);
    run_program(1, -1, 0);
    run_program(2, -1, 0);

    // Abort on the first cycle of RAND pattern 1 while everything misses
    run_program(2, P_RST + 3*P_HOLD + P_WALK*P_CW*P_HOLD, 1);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort.phase",   32'(phase),   32'd0);
    chk("start_abort.busy",    32'(busy),    32'd0);
    chk("start_abort.err_cnt", 32'(err_cnt), 32'(exp_err));

    // Restart reproduces the same patterns; then random scoring runs
    run_program(0, -1, 0);
    for (int r = 0; r < 4; r++) run_program(3, -1, 0);

    // Asynchronous reset on the first ONES cycle
    run_program(3, P_RST + P_HOLD, 2);

    // Program still runs cleanly after the mid-run reset
    run_program(0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
